// File: rtl/bias_add_10_pkg.sv
// Shared sizes and helpers for the layer-10 bias stage.
package bias_add_10_pkg;

  // Layer-10 sizing (coefficient width, output channels, pixels per channel)
  localparam int unsigned COEFF_WIDTH   = 16;
  localparam int unsigned KERN_S_K_10   = 32;
  localparam int unsigned PIX_PER_CH_10 = 64;

  // FIFO handshake strobes produced by the stage in one cycle
  typedef struct packed {
    logic bias_rd;
    logic in_rd;
    logic out_wr;
  } strobe_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_add_10_sat_add.sv
// sat_add: combinational signed add of two W-bit operands, clamped to the W-bit range.
module bias_add_10_sat_add #(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] sum_wide;

  // One extra bit of headroom; the top two bits disagree only on overflow
  always_comb begin
    sum_wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    sum_o    = sum_wide[W-1:0];
    if (sum_wide[W] != sum_wide[W-1]) begin
      sum_o = sum_wide[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/bias_add_10.sv
// Layer-10 bias stage: pops one bias per channel, adds it with saturation to
// every accumulator sample of that channel and pushes the result downstream.
module bias_add_10
  import bias_add_10_pkg::*;
#(
  parameter int unsigned DATA_W     = COEFF_WIDTH,
  parameter int unsigned NUM_CH     = KERN_S_K_10,
  parameter int unsigned PIX_PER_CH = PIX_PER_CH_10
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] bias_V_dout,
  input  logic              bias_V_empty_n,
  output logic              bias_V_read,
  input  logic [DATA_W-1:0] input_V_dout,
  input  logic              input_V_empty_n,
  output logic              input_V_read,
  output logic [DATA_W-1:0] output_V_din,
  input  logic              output_V_full_n,
  output logic              output_V_write,
  output logic              frame_done
);

  localparam int unsigned CH_W  = cnt_w(NUM_CH);
  localparam int unsigned PIX_W = cnt_w(PIX_PER_CH);

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_CH - 1);

  localparam logic [0:0] S_BIAS = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  logic [0:0]        state_q,      state_d;
  logic [CH_W-1:0]   ch_cnt_q,     ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q,    pix_cnt_d;
  logic [DATA_W-1:0] bias_q,       bias_d;
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] dout_q,       dout_d;
  logic              frame_done_q, frame_done_d;

  strobe_t           strb_c;
  logic              accept_c;
  logic [DATA_W-1:0] sum_c;

  // Saturating add of the channel bias onto the accumulator FIFO head
  bias_add_10_sat_add #(
    .W (DATA_W)
  ) u_sat_add (
    .a_i   (input_V_dout),
    .b_i   (bias_q),
    .sum_o (sum_c)
  );

  // Next-state, counters, output register update and FIFO strobes
  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    bias_d       = bias_q;
    out_valid_d  = out_valid_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    accept_c     = 1'b0;
    strb_c       = '0;

    // Pending result drains whenever the output FIFO has room
    strb_c.out_wr = out_valid_q & output_V_full_n;
    if (strb_c.out_wr) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_BIAS: begin
        strb_c.bias_rd = bias_V_empty_n;
        if (bias_V_empty_n) begin
          bias_d    = bias_V_dout;
          pix_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        // A new sample may enter only if the output slot is free or draining now
        accept_c     = input_V_empty_n & (~out_valid_q | output_V_full_n);
        strb_c.in_rd = accept_c;
        if (accept_c) begin
          dout_d      = sum_c;
          out_valid_d = 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            state_d   = S_BIAS;
            if (ch_cnt_q == LAST_CH) begin
              ch_cnt_d     = '0;
              frame_done_d = 1'b1;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end

      default: begin
        state_d = S_BIAS;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= S_BIAS;
      ch_cnt_q     <= '0;
      pix_cnt_q    <= '0;
      bias_q       <= '0;
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      bias_q       <= bias_d;
      out_valid_q  <= out_valid_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Reset state is S_BIAS, so the bias strobe needs explicit masking during reset
  assign bias_V_read    = strb_c.bias_rd & ~ap_rst;
  assign input_V_read   = strb_c.in_rd   & ~ap_rst;
  assign output_V_write = strb_c.out_wr  & ~ap_rst;
  assign output_V_din   = dout_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_bias_add_10.sv
// Bench for bias_add_10: FIFO models driven from queues, scoreboard against a
// plain-arithmetic saturating-add reference, table vectors plus corner sequences.
module tb_bias_add_10;

  localparam int unsigned DW    = 16;
  localparam int unsigned NCH   = 2;
  localparam int unsigned PIX   = 4;
  localparam int          FRAME = int'(NCH * PIX);

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [DW-1:0] bias_V_dout = '0;
  logic          bias_V_empty_n = 1'b0;
  logic          bias_V_read;
  logic [DW-1:0] input_V_dout = '0;
  logic          input_V_empty_n = 1'b0;
  logic          input_V_read;
  logic [DW-1:0] output_V_din;
  logic          output_V_full_n = 1'b1;
  logic          output_V_write;
  logic          frame_done;

  bias_add_10 #(
    .DATA_W     (DW),
    .NUM_CH     (NCH),
    .PIX_PER_CH (PIX)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .bias_V_dout     (bias_V_dout),
    .bias_V_empty_n  (bias_V_empty_n),
    .bias_V_read     (bias_V_read),
    .input_V_dout    (input_V_dout),
    .input_V_empty_n (input_V_empty_n),
    .input_V_read    (input_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write),
    .frame_done      (frame_done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    int bias;
    int x;
    int e;
  } vec_t;

  vec_t tbl [16];

  int bq[$];
  int iq[$];
  int eq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int bias_pops = 0, in_pops = 0, out_writes = 0, fd_cnt = 0;
  int inv_viol = 0, first_kind = 0;
  bit bias_en = 1'b1, in_en = 1'b1, full_ctl = 1'b1, rst_ctl = 1'b1;

  // Reference: exact sum clamped to the signed 16-bit range
  function automatic int sat_ref(input int a, input int b);
    int s;
    s = a + b;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive();
    ap_rst          = rst_ctl;
    bias_V_empty_n  = bias_en && (bq.size() > 0);
    bias_V_dout     = (bq.size() > 0) ? DW'(bq[0]) : '0;
    input_V_empty_n = in_en && (iq.size() > 0);
    input_V_dout    = (iq.size() > 0) ? DW'(iq[0]) : '0;
    output_V_full_n = full_ctl;
  endtask

  // One cycle: drive at the falling edge, then account for what the next rising edge does
  task automatic tick();
    @(negedge ap_clk);
    if (frame_done) begin
      fd_cnt++;
      if ((in_pops % FRAME) != 0) inv_viol++;
    end
    drive();
    #1;
    if (bias_V_read && input_V_read) inv_viol++;
    if ((in_pops != out_writes) && !output_V_full_n && input_V_read) inv_viol++;
    if (ap_rst && (bias_V_read || input_V_read || output_V_write)) inv_viol++;
    if (first_kind == 0) begin
      if (bias_V_read) first_kind = 1;
      else if (input_V_read) first_kind = 2;
    end
    if (output_V_write) begin
      out_writes++;
      if (eq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_extra: got %0d, expected no output", int'($signed(output_V_din)));
      end else begin
        check("out_data", int'($signed(output_V_din)), eq.pop_front());
      end
    end
    if (bias_V_read) begin
      bias_pops++;
      if (bq.size() > 0) void'(bq.pop_front());
      else inv_viol++;
    end
    if (input_V_read) begin
      in_pops++;
      if (iq.size() > 0) void'(iq.pop_front());
      else inv_viol++;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((eq.size() > 0 || in_pops != out_writes) && k < budget) begin
      tick();
      k++;
    end
    repeat (2) tick();
    check(name, int'(k < budget), 1);
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (in_pops < target && k < budget) begin
      tick();
      k++;
    end
    check(name, int'(k < budget), 1);
  endtask

  task automatic push_rows(input int lo);
    for (int i = lo; i < lo + FRAME; i++) begin
      if ((i % int'(PIX)) == 0) bq.push_back(tbl[i].bias);
      iq.push_back(tbl[i].x);
      eq.push_back(tbl[i].e);
    end
  endtask

  // One channel: bias then PIX inputs (random or an incrementing run from x0)
  task automatic push_chan(input int b, input int x0, input bit rnd);
    int x;
    bq.push_back(b);
    for (int k = 0; k < int'(PIX); k++) begin
      x = rnd ? (int'($urandom_range(65535)) - 32768) : x0 + k;
      iq.push_back(x);
      eq.push_back(sat_ref(x, b));
    end
  endtask

  initial begin
    int base, fd0, bp0, p0, d0, k;
    bit din_ok, pop_ok;

    tbl[0]  = '{10, 1, 11};          tbl[1]  = '{10, 2, 12};
    tbl[2]  = '{10, 3, 13};          tbl[3]  = '{10, 4, 14};
    tbl[4]  = '{-5, 5, 0};           tbl[5]  = '{-5, 6, 1};
    tbl[6]  = '{-5, 7, 2};           tbl[7]  = '{-5, 8, 3};
    tbl[8]  = '{100, 32700, 32767};  tbl[9]  = '{100, 5, 105};
    tbl[10] = '{100, 32667, 32767};  tbl[11] = '{100, -32768, -32668};
    tbl[12] = '{-1, -32768, -32768}; tbl[13] = '{-1, -32767, -32768};
    tbl[14] = '{-1, 0, -1};          tbl[15] = '{-1, 32767, 32766};

    // Reset state with data already waiting in the FIFOs
    push_rows(0);
    drive();
    #1;
    check("rst_bias_read", int'(bias_V_read), 0);
    check("rst_input_read", int'(input_V_read), 0);
    check("rst_out_write", int'(output_V_write), 0);
    check("rst_out_din", int'(output_V_din), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst_ctl = 1'b0;

    // Table frames: basic biases, then saturation corners
    wait_drain("basic_drain", 200);
    check("basic_frame_done", fd_cnt, 1);
    check("basic_bias_pops", bias_pops, 2);
    check("basic_in_pops", in_pops, 8);
    check("basic_first_is_bias", first_kind, 1);
    push_rows(8);
    wait_drain("sat_drain", 200);
    check("sat_frame_done", fd_cnt, 2);

    // Backpressure for 5 cycles mid-channel
    base = in_pops;
    push_chan(7, 0, 1'b1);
    push_chan(-3, 0, 1'b1);
    wait_pops("bp_reach", base + 2, 100);
    full_ctl = 1'b0;
    tick();
    d0 = int'(output_V_din);
    p0 = in_pops;
    din_ok = 1'b1;
    pop_ok = 1'b1;
    repeat (5) begin
      tick();
      if (int'(output_V_din) != d0 || output_V_write) din_ok = 1'b0;
      if (input_V_read) pop_ok = 1'b0;
    end
    check("bp_din_stable", int'(din_ok), 1);
    check("bp_no_pop", int'(pop_ok), 1);
    check("bp_pop_count", in_pops, p0);
    full_ctl = 1'b1;
    wait_drain("bp_drain", 200);

    // Input FIFO runs dry mid-channel, then bias FIFO at the channel boundary
    base = in_pops;
    bq.push_back(-20);
    for (int i = 0; i < 2; i++) begin
      iq.push_back(1000 + i);
      eq.push_back(sat_ref(1000 + i, -20));
    end
    wait_pops("ie_reach", base + 2, 100);
    repeat (4) tick();
    check("ie_hold_pops", in_pops, base + 2);
    for (int i = 2; i < int'(PIX); i++) begin
      iq.push_back(1000 + i);
      eq.push_back(sat_ref(1000 + i, -20));
    end
    for (int i = 0; i < int'(PIX); i++) begin
      iq.push_back(-32760 + i);
      eq.push_back(sat_ref(-32760 + i, -9));
    end
    wait_pops("be_reach", base + int'(PIX), 100);
    bp0 = bias_pops;
    pop_ok = 1'b1;
    repeat (3) begin
      tick();
      if (input_V_read) pop_ok = 1'b0;
    end
    check("be_no_input_pop", int'(pop_ok), 1);
    check("be_no_bias_pop", bias_pops, bp0);
    bq.push_back(-9);
    wait_drain("be_drain", 200);

    // Three random frames back-to-back under random FIFO readiness
    fd0 = fd_cnt;
    bp0 = bias_pops;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        push_chan(int'($urandom_range(65535)) - 32768, 0, 1'b1);
      end
    end
    k = 0;
    while ((eq.size() > 0 || in_pops != out_writes) && k < 2000) begin
      bias_en  = ($urandom_range(3) != 0);
      in_en    = ($urandom_range(3) != 0);
      full_ctl = ($urandom_range(3) != 0);
      tick();
      k++;
    end
    bias_en  = 1'b1;
    in_en    = 1'b1;
    full_ctl = 1'b1;
    repeat (2) tick();
    check("mf_finish", int'(k < 2000), 1);
    check("mf_frame_done", fd_cnt - fd0, 3);
    check("mf_bias_pops", bias_pops - bp0, 3 * int'(NCH));

    // Reset in channel 1, pixel 2, with a result stuck behind a full output
    base = in_pops;
    push_chan(3, 100, 1'b0);
    push_chan(4, 200, 1'b0);
    wait_pops("rst_reach", base + int'(PIX) + 2, 100);
    full_ctl = 1'b0;
    tick();
    check("rst_pending", in_pops - out_writes, 1);
    rst_ctl = 1'b1;
    ap_rst  = 1'b1;
    #1;
    check("midrst_out_write", int'(output_V_write), 0);
    check("midrst_out_din", int'(output_V_din), 0);
    check("midrst_input_read", int'(input_V_read), 0);
    check("midrst_bias_read", int'(bias_V_read), 0);
    bq.delete();
    iq.delete();
    eq.delete();
    in_pops    = 0;
    out_writes = 0;
    bias_pops  = 0;
    fd_cnt     = 0;
    first_kind = 0;
    full_ctl   = 1'b1;
    drive();
    tick();
    tick();
    rst_ctl = 1'b0;
    tick();
    push_rows(0);
    wait_drain("post_rst_drain", 200);
    check("post_rst_first_is_bias", first_kind, 1);
    check("post_rst_frame_done", fd_cnt, 1);
    check("post_rst_bias_pops", bias_pops, 2);

    check("invariants", inv_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
